// File: rtl/button_debouncer.sv
// Debounces one synchronized push-button level and emits single-cycle press/release strobes.
// Press strobes are qualified by the game-active enable; release strobes are not.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic sypush,
    input  logic enable,
    output logic db_level,
    output logic press_pulse,
    output logic release_pulse
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        HELD   = 2'd2,
        DISARM = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // The sample that causes a state entry already counts, hence cnt = 1 on ARM/DISARM entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            db_level      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (sypush) begin
                        state <= ARM;
                        cnt   <= CNT_ONE;
                    end
                end
                ARM: begin
                    if (!sypush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= HELD;
                        cnt         <= '0;
                        db_level    <= 1'b1;
                        press_pulse <= enable;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!sypush) begin
                        state <= DISARM;
                        cnt   <= CNT_ONE;
                    end
                end
                DISARM: begin
                    if (sypush) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        db_level      <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    db_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Debounces one synchronized push-button level and turns each accepted press into a single-cycle event for the game logic. It sits directly downstream of the per-button synchronizer: it consumes `sypush` and feeds the rope-position controller. There is one instance per player button. Presses are only reported while the game is enabled, so a button held before the round starts cannot score.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical samples required to accept a level change; must be ≥ 2. The board build sets 500000 (10 ms at 50 MHz).
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sypush`  in  1  synchronized button level (1 = pressed); already free of metastability.
- `enable`  in  1  game-active qualifier for `press_pulse`.
- `db_level`  out  1  debounced button level.
- `press_pulse`  out  1  one-cycle strobe per accepted press, gated by `enable`.
- `release_pulse`  out  1  one-cycle strobe per accepted release; not gated.

## Operation
- Four states:
  - IDLE: `db_level` = 0.
  - ARM: candidate press.
  - HELD: `db_level` = 1.
  - DISARM: candidate release.
- Counter `cnt` (CNT_W bits) counts consecutive samples that match the candidate level. It is cleared on every state entry except as noted below.
- IDLE, `sypush`=1: go to ARM with `cnt` = 1; this sample counts. IDLE, `sypush`=0: stay in IDLE.
- ARM, `sypush`=0: go to IDLE (glitch rejected), `cnt` = 0, no pulse.
- ARM, `sypush`=1 and `cnt` = DEBOUNCE_CYCLES−1: go to HELD. Assert `press_pulse` for this one cycle only if `enable`=1 at this edge.
- ARM, `sypush`=1 otherwise: increment `cnt`.
- HELD, `sypush`=0: go to DISARM with `cnt` = 1. HELD, `sypush`=1: stay in HELD.
- DISARM, `sypush`=1: go back to HELD, `cnt` = 0, no pulse.
- DISARM, `sypush`=0 and `cnt` = DEBOUNCE_CYCLES−1: go to IDLE and assert `release_pulse` for one cycle.
- DISARM, `sypush`=0 otherwise: increment `cnt`.
- `db_level` is 1 in HELD and DISARM, 0 in IDLE and ARM. It is driven from a register, not decoded combinationally from `sypush`.
- `enable` affects only `press_pulse`:
  - A press that completes debounce while `enable`=0 still moves the FSM to HELD but emits no pulse.
  - A later rise of `enable` never produces a retroactive pulse.
- At most one press pulse per press-release cycle; holding the button produces no repeats.
- `cnt` never exceeds DEBOUNCE_CYCLES−1, so it cannot wrap.

## Timing
- Reset: state IDLE, `cnt` = 0, `db_level` = 0, `press_pulse` = 0, `release_pulse` = 0. These values are visible after the first rising edge with `rst`=1.
- `rst` has priority over every other input. Reset mid-ARM or mid-DISARM discards the partial count.
- If `sypush` is still 1 after reset, a fresh debounce runs and a press pulse is emitted (when enabled) after DEBOUNCE_CYCLES samples.
- Press latency: the first high sample is at edge k. `press_pulse` and `db_level` go high after edge k+DEBOUNCE_CYCLES−1, i.e. DEBOUNCE_CYCLES edges of `sypush`=1 in total.
- `press_pulse` drops after the next edge.
- Release latency is symmetric: `release_pulse` is high after the DEBOUNCE_CYCLES-th consecutive low sample, and `db_level` falls on the same edge.
- `press_pulse` and `release_pulse` are never high in the same cycle. Neither stays high for more than one cycle.
- Minimum spacing between two press pulses is 2×DEBOUNCE_CYCLES cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 unless stated.
- Reset: hold `rst`=1 for 2 cycles with `sypush`=1 → all outputs 0. After release, `press_pulse`=1 exactly 4 edges later, with `enable`=1.
- Clean press: `enable`=1, `sypush` 0→1 held 10 cycles → one `press_pulse` on the 4th high sample; `db_level`=1 from that cycle on; no further pulses.
- Glitch rejection: `sypush` high for 3 cycles, low for 1, high for 3, then low → no `press_pulse`, and `db_level` stays 0 throughout.
- Release bounce: from HELD, `sypush` low 2 cycles, high 1, then low 4 → no `release_pulse` after the first dip. `release_pulse`=1 on the 4th consecutive low sample, and `db_level` falls on the same edge.
- Enable gating: press completes while `enable`=0 → `press_pulse` stays 0 and `db_level`=1. Raise `enable` while still held → no pulse. Release, then press again → one pulse.
- Reset mid-operation: assert `rst` for 1 cycle while in ARM with `cnt`=2 → back to IDLE. A subsequent full press of 4 samples yields exactly one pulse, with latency counted from scratch.
